cla_pipe_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready handshake. It generalises the fixed 8-bit combinational CLA to any width. The datapath is split into STAGES register-separated slices, each built from GROUP-bit lookahead blocks, with the carry passed between slices through registers. It adds a subtract mode, signed-overflow and zero flags, and full backpressure, and serves as the arithmetic primitive for the wider datapaths in basic_circuits.

---
 rtl/cla_pipe_adder.sv | 154 +++++++++++++++
 tb/tb_cla_pipe_adder.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - pipelined carry-lookahead adder/subtractor with valid/ready handshake
// Slice k adds bits [k*SW +: SW] in pipeline stage k; higher operand bits ride along until needed.
module cla_pipe_adder #(
  parameter int WIDTH  = 8,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SW = WIDTH / STAGES;
  localparam int NG = SW / GROUP;

  if ((STAGES < 1) || (WIDTH % (STAGES * GROUP) != 0)) begin : g_bad_params
    $error("cla_pipe_adder: WIDTH must be a multiple of STAGES*GROUP");
  end

  logic en;

  // Returns carry into every bit of the slice plus carry out (bit SW), in sum-of-products form.
  function automatic logic [SW:0] slice_carries(input logic [SW-1:0] x,
                                                input logic [SW-1:0] y,
                                                input logic ci);
    logic [SW-1:0] g, p;
    logic [NG-1:0] gg, pg;
    logic [NG:0]   cg;
    logic [SW:0]   c;
    logic          t, u;
    g = x & y;
    p = x ^ y;
    for (int j = 0; j < NG; j++) begin
      gg[j] = 1'b0;
      pg[j] = 1'b1;
      for (int i = 0; i < GROUP; i++) begin
        t = g[j*GROUP+i];
        for (int m = i + 1; m < GROUP; m++) t = t & p[j*GROUP+m];
        gg[j] = gg[j] | t;
        pg[j] = pg[j] & p[j*GROUP+i];
      end
    end
    for (int j = 0; j <= NG; j++) begin
      cg[j] = ci;
      for (int m = 0; m < j; m++) cg[j] = cg[j] & pg[m];
      for (int i = 0; i < j; i++) begin
        t = gg[i];
        for (int m = i + 1; m < j; m++) t = t & pg[m];
        cg[j] = cg[j] | t;
      end
    end
    c = '0;
    for (int j = 0; j < NG; j++) begin
      for (int k = 0; k < GROUP; k++) begin
        t = cg[j];
        for (int m = 0; m < k; m++) t = t & p[j*GROUP+m];
        for (int i = 0; i < k; i++) begin
          u = g[j*GROUP+i];
          for (int m = i + 1; m < k; m++) u = u & p[j*GROUP+m];
          t = t | u;
        end
        c[j*GROUP+k] = t;
      end
    end
    c[SW] = cg[NG];
    return c;
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int REM = WIDTH - k * SW;
    localparam int SB  = (k + 1) * SW;

    logic [REM-1:0] a_in, b_in;
    logic           ci, v_in;
    logic [SW:0]    cc;
    logic [SW-1:0]  ss;
    logic [SB-1:0]  s_all, s_r;
    logic           v_r, c_r;

    if (k == 0) begin : g_first
      assign a_in  = a;
      assign b_in  = sub ? ~b : b;
      assign ci    = sub | cin;
      assign v_in  = in_valid;
      assign s_all = ss;
    end else begin : g_next
      assign a_in  = g_st[k-1].g_ops.a_r;
      assign b_in  = g_st[k-1].g_ops.b_r;
      assign ci    = g_st[k-1].c_r;
      assign v_in  = g_st[k-1].v_r;
      assign s_all = {ss, g_st[k-1].s_r};
    end

    assign cc = slice_carries(a_in[SW-1:0], b_in[SW-1:0], ci);
    assign ss = a_in[SW-1:0] ^ b_in[SW-1:0] ^ cc[SW-1:0];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_r <= 1'b0;
        c_r <= 1'b0;
        s_r <= '0;
      end else if (en) begin
        v_r <= v_in;
        c_r <= cc[SW];
        s_r <= s_all;
      end
    end

    if (k < STAGES - 1) begin : g_ops
      logic [REM-SW-1:0] a_r, b_r;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_r <= '0;
          b_r <= '0;
        end else if (en) begin
          a_r <= a_in[REM-1:SW];
          b_r <= b_in[REM-1:SW];
        end
      end
    end else begin : g_flags
      logic ovf_r, zero_r;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_r  <= 1'b0;
          zero_r <= 1'b0;
        end else if (en) begin
          ovf_r  <= cc[SW] ^ cc[SW-1];
          zero_r <= (s_all == '0);
        end
      end
    end
  end

  // Whole pipe advances in lockstep; a stalled output freezes every stage.
  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = g_st[STAGES-1].v_r;
  assign sum       = g_st[STAGES-1].s_r;
  assign cout      = g_st[STAGES-1].c_r;
  assign ovf       = g_st[STAGES-1].g_flags.ovf_r;
  assign zero      = g_st[STAGES-1].g_flags.zero_r;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb/tb_cla_pipe_adder.sv - scoreboard bench for cla_pipe_adder (8/2, 32/4 and 16/1 configurations)
module tb_cla_pipe_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        o;
    logic        z;
  } res_t;

  typedef struct {
    res_t r;
    int   t;
  } exp_t;

  exp_t q[$];

  logic        iv8, ir8, cin8, sub8, ov8, or8, co8, of8, z8;
  logic [7:0]  a8, b8, s8;
  logic        iv32, ir32, cin32, sub32, ov32, or32, co32, of32, z32;
  logic [31:0] a32, b32, s32;
  logic        iv16, ir16, cin16, sub16, ov16, or16, co16, of16, z16;
  logic [15:0] a16, b16, s16;

  cla_pipe_adder #(.WIDTH(8), .GROUP(4), .STAGES(2)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .ovf(of8), .zero(z8));

  cla_pipe_adder #(.WIDTH(32), .GROUP(4), .STAGES(4)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .cin(cin32), .sub(sub32),
    .out_valid(ov32), .out_ready(or32), .sum(s32), .cout(co32), .ovf(of32), .zero(z32));

  cla_pipe_adder #(.WIDTH(16), .GROUP(4), .STAGES(1)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .cin(cin16), .sub(sub16),
    .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16), .ovf(of16), .zero(z16));

  function automatic res_t ref_model(input int w, input logic [31:0] x, input logic [31:0] y,
                                     input logic ci, input logic sb);
    logic [31:0] mask, yy;
    logic [32:0] full;
    res_t r;
    mask = (w == 32) ? 32'hffff_ffff : ((32'd1 << w) - 32'd1);
    yy   = (sb ? ~y : y) & mask;
    full = {1'b0, x & mask} + {1'b0, yy} + {32'd0, (sb ? 1'b1 : ci)};
    r.s  = full[31:0] & mask;
    r.c  = full[w];
    r.o  = (x[w-1] == yy[w-1]) && (r.s[w-1] != x[w-1]);
    r.z  = (r.s == 32'd0);
    return r;
  endfunction

  task automatic drive8(input logic iv, input logic [7:0] x, input logic [7:0] y,
                        input logic ci, input logic sb, input logic ordy);
    @(negedge clk);
    iv8 = iv; a8 = x; b8 = y; cin8 = ci; sub8 = sb; or8 = ordy;
    #1;
  endtask

  task automatic drive32(input logic iv, input logic [31:0] x, input logic [31:0] y,
                         input logic ci, input logic sb, input logic ordy);
    @(negedge clk);
    iv32 = iv; a32 = x; b32 = y; cin32 = ci; sub32 = sb; or32 = ordy;
    #1;
  endtask

  task automatic drive16(input logic iv, input logic [15:0] x, input logic [15:0] y,
                         input logic ci, input logic sb, input logic ordy);
    @(negedge clk);
    iv16 = iv; a16 = x; b16 = y; cin16 = ci; sub16 = sb; or16 = ordy;
    #1;
  endtask

  task automatic test_reset();
    iv8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0; or8 = 1;
    iv32 = 0; a32 = 0; b32 = 0; cin32 = 0; sub32 = 0; or32 = 1;
    iv16 = 0; a16 = 0; b16 = 0; cin16 = 0; sub16 = 0; or16 = 1;
    rst = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", ov8); end
    checks++; if (s8 !== 8'd0) begin errors++; $display("FAIL reset_sum got %h want 00", s8); end
    checks++; if ({co8, of8, z8} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {co8, of8, z8}); end
    checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", ir8); end
    checks++; if ({ov32, s32, co32, of32, z32} !== 36'd0) begin errors++; $display("FAIL reset_w32 got %h want 0", {ov32, s32, co32, of32, z32}); end
    checks++; if ({ov16, s16, co16, of16, z16} !== 20'd0) begin errors++; $display("FAIL reset_w16 got %h want 0", {ov16, s16, co16, of16, z16}); end
  endtask

  task automatic test_basic();
    logic [7:0] va [5];
    logic [7:0] vb [5];
    logic       vc [5];
    logic       vs [5];
    logic [7:0] es [5];
    logic [2:0] ef [5];
    int         sent = 0;
    int         got = 0;
    exp_t       e;
    va = '{8'd2, 8'd128, 8'd75, 8'd20, 8'd5};
    vb = '{8'd5, 8'd128, 8'd75, 8'd20, 8'd7};
    vc = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vs = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    es = '{8'd7, 8'd0, 8'd151, 8'd0, 8'd254};
    ef = '{3'b000, 3'b111, 3'b010, 3'b101, 3'b000};
    q.delete();
    for (int j = 0; j < 12; j++) begin
      if (sent < 5) drive8(1, va[sent], vb[sent], vc[sent], vs[sent], 1);
      else drive8(0, 0, 0, 0, 0, 1);
      if (ov8 && or8) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL basic_extra_result sum %h", s8); end
        else begin
          e = q.pop_front();
          got++;
          if ({s8, co8, of8, z8} !== {e.r.s[7:0], e.r.c, e.r.o, e.r.z})
            begin errors++; $display("FAIL basic_result got %h/%b want %h/%b", s8, {co8, of8, z8}, e.r.s[7:0], {e.r.c, e.r.o, e.r.z}); end
          checks++;
          if (cyc - e.t != 2) begin errors++; $display("FAIL basic_latency got %0d want 2", cyc - e.t); end
        end
      end
      if (iv8 && ir8) begin
        e.r.s = {24'd0, es[sent]};
        {e.r.c, e.r.o, e.r.z} = ef[sent];
        e.t = cyc;
        q.push_back(e);
        sent++;
      end
    end
    checks++; if (got != 5 || q.size() != 0) begin errors++; $display("FAIL basic_count got %0d want 5", got); end
  endtask

  task automatic test_back_to_back();
    int         sent = 0;
    int         got = 0;
    logic [7:0] held = 0;
    logic       ordy;
    exp_t       e;
    q.delete();
    for (int j = 0; j < 40 && got < 8; j++) begin
      ordy = !(j >= 4 && j < 7);
      if (sent < 8) drive8(1, 8'(sent), 8'(3 * sent), 0, 0, ordy);
      else drive8(0, 0, 0, 0, 0, ordy);
      if (j >= 4 && j < 7) begin
        checks++;
        if (ir8 !== 1'b0 || ov8 !== 1'b1) begin errors++; $display("FAIL b2b_stall_ready cycle %0d in_ready %b out_valid %b want 0 1", j, ir8, ov8); end
        if (j == 4) held = s8;
        else begin
          checks++;
          if (s8 !== held) begin errors++; $display("FAIL b2b_stall_hold got %h want %h", s8, held); end
        end
      end
      if (ov8 && or8) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL b2b_extra_result sum %h", s8); end
        else begin
          e = q.pop_front();
          got++;
          if ({s8, co8, of8, z8} !== {e.r.s[7:0], e.r.c, e.r.o, e.r.z})
            begin errors++; $display("FAIL b2b_result %0d got %h want %h", got, s8, e.r.s[7:0]); end
        end
      end
      if (iv8 && ir8) begin
        e.r = ref_model(8, 32'(sent), 32'(3 * sent), 0, 0);
        e.t = cyc;
        q.push_back(e);
        sent++;
      end
    end
    drive8(0, 0, 0, 0, 0, 1);
    checks++; if (got != 8 || q.size() != 0 || ov8 !== 1'b0) begin errors++; $display("FAIL b2b_count got %0d want 8", got); end
  endtask

  task automatic test_reset_midflight();
    q.delete();
    drive8(1, 8'd10, 8'd20, 0, 0, 0);
    drive8(1, 8'd30, 8'd40, 0, 0, 0);
    drive8(0, 0, 0, 0, 0, 0);
    checks++; if (ov8 !== 1'b1 || s8 !== 8'd30) begin errors++; $display("FAIL midrst_pre got %b/%h want 1/1e", ov8, s8); end
    rst = 1;
    #1;
    checks++; if ({ov8, s8, co8, of8, z8} !== 12'd0) begin errors++; $display("FAIL midrst_clear got %h want 000", {ov8, s8, co8, of8, z8}); end
    checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", ir8); end
    @(negedge clk);
    rst = 0;
    for (int j = 0; j < 6; j++) begin
      drive8(0, 0, 0, 0, 0, 1);
      checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL midrst_ghost cycle %0d got %b want 0", j, ov8); end
    end
    drive8(1, 8'd100, 8'd1, 1, 0, 1);
    drive8(0, 0, 0, 0, 0, 1);
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL midrst_early got %b want 0", ov8); end
    drive8(0, 0, 0, 0, 0, 1);
    checks++; if (ov8 !== 1'b1 || s8 !== 8'd102) begin errors++; $display("FAIL midrst_new got %b/%h want 1/66", ov8, s8); end
    drive8(0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_sweep32();
    int          sent = 0;
    int          got = 0;
    int          minlat = 1000000;
    logic [31:0] x, y;
    logic        ci, sb, iv;
    exp_t        e;
    q.delete();
    for (int j = 0; j < 6000 && (sent < 1000 || q.size() > 0); j++) begin
      iv = (sent < 1000) && ($urandom_range(0, 4) != 0);
      x = $urandom; y = $urandom;
      ci = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
      drive32(iv, x, y, ci, sb, $urandom_range(0, 3) != 0);
      if (ov32 && or32) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL w32_extra_result sum %h", s32); end
        else begin
          e = q.pop_front();
          got++;
          if ({s32, co32, of32, z32} !== {e.r.s, e.r.c, e.r.o, e.r.z})
            begin errors++; $display("FAIL w32_result %0d got %h/%b want %h/%b", got, s32, {co32, of32, z32}, e.r.s, {e.r.c, e.r.o, e.r.z}); end
          if (cyc - e.t < minlat) minlat = cyc - e.t;
        end
      end
      if (iv32 && ir32) begin
        e.r = ref_model(32, x, y, ci, sb);
        e.t = cyc;
        q.push_back(e);
        sent++;
      end
    end
    checks++; if (got != 1000 || q.size() != 0) begin errors++; $display("FAIL w32_count got %0d want 1000", got); end
    checks++; if (minlat != 4) begin errors++; $display("FAIL w32_latency got %0d want 4", minlat); end
  endtask

  task automatic test_sweep16();
    int          sent = 0;
    int          got = 0;
    int          minlat = 1000000;
    logic [15:0] x, y;
    logic        ci, sb, iv;
    exp_t        e;
    q.delete();
    for (int j = 0; j < 6000 && (sent < 1000 || q.size() > 0); j++) begin
      iv = (sent < 1000) && ($urandom_range(0, 4) != 0);
      x = 16'($urandom); y = 16'($urandom);
      ci = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
      drive16(iv, x, y, ci, sb, $urandom_range(0, 3) != 0);
      if (ov16 && or16) begin
        checks++;
        if (q.size() == 0) begin errors++; $display("FAIL w16_extra_result sum %h", s16); end
        else begin
          e = q.pop_front();
          got++;
          if ({16'd0, s16, co16, of16, z16} !== {e.r.s, e.r.c, e.r.o, e.r.z})
            begin errors++; $display("FAIL w16_result %0d got %h/%b want %h/%b", got, s16, {co16, of16, z16}, e.r.s[15:0], {e.r.c, e.r.o, e.r.z}); end
          if (cyc - e.t < minlat) minlat = cyc - e.t;
        end
      end
      if (iv16 && ir16) begin
        e.r = ref_model(16, {16'd0, x}, {16'd0, y}, ci, sb);
        e.t = cyc;
        q.push_back(e);
        sent++;
      end
    end
    checks++; if (got != 1000 || q.size() != 0) begin errors++; $display("FAIL w16_count got %0d want 1000", got); end
    checks++; if (minlat != 1) begin errors++; $display("FAIL w16_latency got %0d want 1", minlat); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_midflight();
    test_sweep32();
    test_sweep16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
